// File: rtl/i2c_bridge_pkg.sv
// Shared constants for the TramelBlaze-to-I2C burst bridge.
// Latency: none (constants and types only).
// Backpressure: none (constants and types only).
package i2c_bridge_pkg;

    // Register offsets from BASE_PORT
    localparam logic [15:0] OFF_ADDR   = 16'd0;
    localparam logic [15:0] OFF_TXD    = 16'd1;
    localparam logic [15:0] OFF_CMD    = 16'd2;
    localparam logic [15:0] OFF_STATUS = 16'd3;

    // CMD write bits
    localparam int CMD_START = 0;
    localparam int CMD_FLUSH = 1;
    localparam int CMD_IEN   = 2;

    // STATUS read bits
    localparam int ST_READY   = 0;
    localparam int ST_BUSY    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_FULL    = 3;
    localparam int ST_OVF     = 4;
    localparam int ST_TOUT    = 5;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_DONE
    } state_t;

endpackage

// File: rtl/i2c_tb_burst_bridge_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear; dout shows the head combinationally.
// Latency: a push is visible at dout/count one cycle later; a pop takes effect on the same edge.
// Backpressure: a push while full is dropped unless a pop frees the slot in that cycle; clr wins over push/pop.
// Ports: clk, rst (async, active-high), push/din, pop, clr -> dout, full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty && !clr;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign do_push = push && !clr && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_tb_burst_bridge.sv
// TramelBlaze port-bus to I2C-core bridge: address/TX FIFO/CMD/STATUS window plus a burst sequencer.
// Latency: START write to first i2c_start_o is 2 cycles; one LOAD cycle between bytes after the core re-readies.
// Backpressure: TX pushes while full are dropped (sticky OVF); the core paces bytes with i2c_ready_i, bounded by a timeout.
// Ports: TB bus (port_id/data/strobes/irq/ack), I2C core (ready in; address/data/start out); clk, rst async active-high.
module i2c_tb_burst_bridge
    import i2c_bridge_pkg::*;
#(
    parameter logic [15:0] BASE_PORT   = 16'h0010,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] tb_port_id_i,
    input  logic [15:0] tb_data_i,
    input  logic        tb_write_st_i,
    input  logic        tb_read_st_i,
    input  logic        tb_intr_ack_i,
    output logic        tb_intr_r_o,
    output logic [15:0] tb_data_o,
    input  logic        i2c_ready_i,
    output logic [6:0]  i2c_address_o,
    output logic [7:0]  i2c_data_o,
    output logic        i2c_start_o
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int            TW      = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TCNT_ONE = TW'(1);

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [6:0]    shadow_addr;
    logic          ien;
    logic          ovf;
    logic          tout;

    logic          wr_addr, wr_txd, wr_cmd, rd_status, rd_addr;
    logic          cmd_start, cmd_flush;
    logic          fifo_pop, fifo_clr, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          timeout_hit;
    logic [15:0]   status;
    logic          unused_data_bits;

    assign unused_data_bits = &{1'b0, tb_data_i[15:8]};

    assign wr_addr   = tb_write_st_i && (tb_port_id_i == BASE_PORT + OFF_ADDR);
    assign wr_txd    = tb_write_st_i && (tb_port_id_i == BASE_PORT + OFF_TXD);
    assign wr_cmd    = tb_write_st_i && (tb_port_id_i == BASE_PORT + OFF_CMD);
    assign rd_addr   = tb_read_st_i  && (tb_port_id_i == BASE_PORT + OFF_ADDR);
    assign rd_status = tb_read_st_i  && (tb_port_id_i == BASE_PORT + OFF_STATUS);
    assign cmd_start = wr_cmd && tb_data_i[CMD_START];
    assign cmd_flush = wr_cmd && tb_data_i[CMD_FLUSH];

    assign timeout_hit = (state == S_REQ) && i2c_ready_i && (tcnt == TMAX);
    assign fifo_pop    = (state == S_LOAD);
    assign fifo_clr    = cmd_flush || timeout_hit;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txd),
        .din   (tb_data_i[7:0]),
        .pop   (fifo_pop),
        .clr   (fifo_clr),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                      = '0;
        status[ST_READY]            = i2c_ready_i;
        status[ST_BUSY]             = (state != S_IDLE);
        status[ST_EMPTY]            = fifo_empty;
        status[ST_FULL]             = fifo_full;
        status[ST_OVF]              = ovf;
        status[ST_TOUT]             = tout;
        status[ST_CNT_LSB +: CW]    = fifo_count;
    end

    always_comb begin
        tb_data_o = '0;
        if (rd_addr) begin
            tb_data_o = {9'b0, shadow_addr};
        end else if (rd_status) begin
            tb_data_o = status;
        end
    end

    // Control registers and the overflow flag. A drop and a STATUS read in the
    // same cycle leave OVF set so the event is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_addr <= '0;
            ien         <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            if (wr_addr) shadow_addr <= tb_data_i[6:0];
            if (wr_cmd)  ien         <= tb_data_i[CMD_IEN];
            if (rd_status) ovf <= 1'b0;
            if (wr_txd && fifo_full && !fifo_pop) ovf <= 1'b1;
        end
    end

    // Burst sequencer. Later assignments to tout/irq override the clears above
    // them, giving set-over-clear priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            tcnt          <= '0;
            tout          <= 1'b0;
            tb_intr_r_o   <= 1'b0;
            i2c_address_o <= '0;
            i2c_data_o    <= '0;
            i2c_start_o   <= 1'b0;
        end else begin
            if (rd_status)     tout        <= 1'b0;
            if (tb_intr_ack_i) tb_intr_r_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_start && !cmd_flush && !fifo_empty) begin
                        i2c_address_o <= shadow_addr;
                        state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    i2c_data_o  <= fifo_dout;
                    tcnt        <= '0;
                    i2c_start_o <= 1'b1;
                    state       <= S_REQ;
                end
                S_REQ: begin
                    if (!i2c_ready_i) begin
                        i2c_start_o <= 1'b0;
                        state       <= S_WAIT_LOW;
                    end else if (tcnt == TMAX) begin
                        i2c_start_o <= 1'b0;
                        tout        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TCNT_ONE;
                    end
                end
                S_WAIT_LOW: begin
                    state <= S_WAIT_HIGH;
                end
                S_WAIT_HIGH: begin
                    // A flush landing this cycle must not send us to pop an emptied FIFO.
                    if (i2c_ready_i) begin
                        if (!fifo_empty && !cmd_flush) state <= S_LOAD;
                        else                           state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ien) tb_intr_r_o <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_tb_burst_bridge.sv
// Self-checking bench for i2c_tb_burst_bridge: directed scenarios plus randomized bursts.
// A simple I2C core model drops ready for a programmable time on each accepted start.
module tb_i2c_tb_burst_bridge;

    localparam logic [15:0] BASE    = 16'h0010;
    localparam int          DEPTH   = 8;
    localparam int          TOUT_C  = 64;
    localparam logic [15:0] R_ADDR  = 16'd0;
    localparam logic [15:0] R_TXD   = 16'd1;
    localparam logic [15:0] R_CMD   = 16'd2;
    localparam logic [15:0] R_STAT  = 16'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] port_id = '0;
    logic [15:0] data_in = '0;
    logic        write_st = 1'b0;
    logic        read_st = 1'b0;
    logic        intr_ack = 1'b0;
    logic        ready = 1'b1;
    logic        irq;
    logic [15:0] data_out;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_data;
    logic        i2c_start;

    int total = 0;
    int bad = 0;

    // Core model and monitor state
    bit         core_en = 1'b1;
    int         low_cycles = 10;
    logic [7:0] got_data[$];
    logic [6:0] got_addr[$];
    int         start_rises = 0;
    int         irq_rises = 0;

    i2c_tb_burst_bridge #(
        .BASE_PORT   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TOUT_C)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tb_port_id_i  (port_id),
        .tb_data_i     (data_in),
        .tb_write_st_i (write_st),
        .tb_read_st_i  (read_st),
        .tb_intr_ack_i (intr_ack),
        .tb_intr_r_o   (irq),
        .tb_data_o     (data_out),
        .i2c_ready_i   (ready),
        .i2c_address_o (i2c_addr),
        .i2c_data_o    (i2c_data),
        .i2c_start_o   (i2c_start)
    );

    always #5 clk = ~clk;

    // I2C core model: accepts a start when idle, records the byte, busy for low_cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) continue;
            if (core_en && i2c_start && ready) begin
                got_data.push_back(i2c_data);
                got_addr.push_back(i2c_addr);
                ready = 1'b0;
                repeat (low_cycles) @(posedge clk);
                #1;
                ready = 1'b1;
            end
        end
    end

    // Edge monitor for start pulses and interrupts
    initial begin
        logic ps, pi;
        ps = 1'b0;
        pi = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (i2c_start && !ps) start_rises++;
            if (irq && !pi) irq_rises++;
            ps = i2c_start;
            pi = irq;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tb_write(input logic [15:0] off, input logic [15:0] d);
        @(negedge clk);
        port_id  = BASE + off;
        data_in  = d;
        write_st = 1'b1;
        @(negedge clk);
        write_st = 1'b0;
    endtask

    task automatic tb_read(input logic [15:0] off, output logic [15:0] d);
        @(negedge clk);
        port_id = BASE + off;
        read_st = 1'b1;
        #1;
        d = data_out;
        @(negedge clk);
        read_st = 1'b0;
    endtask

    task automatic wait_irq(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (irq) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rise(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (start_rises > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack_irq();
        @(negedge clk);
        intr_ack = 1'b1;
        @(negedge clk);
        intr_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] r;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({irq, i2c_start, i2c_addr, i2c_data, data_out} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got irq=%b start=%b addr=%h data=%h dout=%h, want all 0",
                     irq, i2c_start, i2c_addr, i2c_data, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        tb_read(R_STAT, r);
        total++;
        if (r !== 16'h0005) begin
            bad++;
            $display("FAIL reset_status: got %h want 0005", r);
        end
        tb_read(R_ADDR, r);
        total++;
        if (r !== 16'h0000) begin
            bad++;
            $display("FAIL reset_addr: got %h want 0000", r);
        end
    endtask

    task automatic test_basic_burst();
        logic [7:0]  exp_b[3];
        logic [15:0] r;
        bit          ok;
        int          base_s;
        exp_b = '{8'h11, 8'h22, 8'h33};
        got_data.delete();
        got_addr.delete();
        core_en    = 1'b1;
        low_cycles = 10;
        base_s     = start_rises;
        tb_write(R_ADDR, 16'h003C);
        for (int i = 0; i < 3; i++) tb_write(R_TXD, {8'h00, exp_b[i]});
        tb_write(R_CMD, 16'h0005);
        total++;
        if (i2c_start !== 1'b0) begin
            bad++;
            $display("FAIL start_latency_early: start=%b one cycle after START, want 0", i2c_start);
        end
        @(posedge clk);
        #1;
        total++;
        if (i2c_start !== 1'b1) begin
            bad++;
            $display("FAIL start_latency: start=%b two cycles after START, want 1", i2c_start);
        end
        // Shadow update while busy must not disturb the in-flight address.
        tb_write(R_ADDR, 16'h007F);
        wait_irq(1000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_irq: no interrupt within budget");
        end
        total++;
        if (start_rises - base_s != 3 || got_data.size() != 3) begin
            bad++;
            $display("FAIL basic_count: pulses=%0d bytes=%0d want 3/3", start_rises - base_s, got_data.size());
        end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            total++;
            if (got_data[i] !== exp_b[i] || got_addr[i] !== 7'h3C) begin
                bad++;
                $display("FAIL basic_byte%0d: got data=%h addr=%h want %h/3c", i, got_data[i], got_addr[i], exp_b[i]);
            end
        end
        tb_read(R_ADDR, r);
        total++;
        if (r !== 16'h007F) begin
            bad++;
            $display("FAIL busy_addr_shadow: got %h want 007f", r);
        end
        ack_irq();
        #1;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_ack: irq=%b after ack, want 0", irq);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] r;
        tb_write(R_CMD, 16'h0002);
        for (int i = 0; i < 9; i++) tb_write(R_TXD, 16'($urandom_range(0, 255)));
        tb_read(R_STAT, r);
        total++;
        if (r[14:8] !== 7'd8 || r[3] !== 1'b1 || r[4] !== 1'b1 || r[2] !== 1'b0) begin
            bad++;
            $display("FAIL ovf_status: got cnt=%0d full=%b ovf=%b empty=%b want 8/1/1/0", r[14:8], r[3], r[4], r[2]);
        end
        tb_read(R_STAT, r);
        total++;
        if (r[4] !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: ovf=%b after STATUS read, want 0", r[4]);
        end
        tb_write(R_CMD, 16'h0002);
        tb_read(R_STAT, r);
        total++;
        if (r[2] !== 1'b1 || r[14:8] !== 7'd0) begin
            bad++;
            $display("FAIL flush_idle: empty=%b cnt=%0d want 1/0", r[2], r[14:8]);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] r;
        bit          ok;
        int          hi;
        core_en = 1'b0;
        tb_write(R_TXD, 16'h00AA);
        tb_write(R_TXD, 16'h00BB);
        tb_write(R_CMD, 16'h0005);
        wait_rise(start_rises - 1, 10, ok);
        hi = 0;
        if (i2c_start) begin
            hi = 1;
            for (int i = 0; i < 4 * TOUT_C; i++) begin
                @(posedge clk);
                #1;
                if (!i2c_start) break;
                hi++;
            end
        end
        total++;
        if (hi != TOUT_C) begin
            bad++;
            $display("FAIL timeout_len: start high %0d cycles, want %0d", hi, TOUT_C);
        end
        wait_irq(20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL timeout_irq: no interrupt after timeout");
        end
        tb_read(R_STAT, r);
        total++;
        if (r[5] !== 1'b1 || r[2] !== 1'b1 || r[14:8] !== 7'd0 || r[1] !== 1'b0 || i2c_start !== 1'b0) begin
            bad++;
            $display("FAIL timeout_status: tout=%b empty=%b cnt=%0d busy=%b start=%b want 1/1/0/0/0",
                     r[5], r[2], r[14:8], r[1], i2c_start);
        end
        tb_read(R_STAT, r);
        total++;
        if (r[5] !== 1'b0) begin
            bad++;
            $display("FAIL tout_clear: tout=%b after read, want 0", r[5]);
        end
        ack_irq();
        core_en = 1'b1;
    endtask

    task automatic test_empty_start();
        logic [15:0] r;
        int          base_s, base_i;
        base_s = start_rises;
        base_i = irq_rises;
        tb_write(R_CMD, 16'h0005);
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (start_rises != base_s || irq_rises != base_i || irq !== 1'b0) begin
            bad++;
            $display("FAIL empty_start: pulses=%0d irqs=%0d want 0/0", start_rises - base_s, irq_rises - base_i);
        end
        tb_read(R_STAT, r);
        total++;
        if (r[1] !== 1'b0) begin
            bad++;
            $display("FAIL empty_start_busy: busy=%b want 0", r[1]);
        end
    endtask

    task automatic test_flush_mid_burst();
        logic [7:0]  b[4];
        logic [15:0] r;
        bit          ok;
        int          base_s;
        got_data.delete();
        got_addr.delete();
        low_cycles = 10;
        base_s = start_rises;
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom_range(0, 255));
            tb_write(R_TXD, {8'h00, b[i]});
        end
        tb_write(R_CMD, 16'h0005);
        wait_rise(base_s, 50, ok);
        tb_write(R_CMD, 16'h0006);
        wait_irq(500, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL flush_irq: no DONE interrupt after flush");
        end
        total++;
        if (start_rises - base_s != 1 || got_data.size() != 1) begin
            bad++;
            $display("FAIL flush_pulses: pulses=%0d bytes=%0d want 1/1", start_rises - base_s, got_data.size());
        end else begin
            total++;
            if (got_data[0] !== b[0]) begin
                bad++;
                $display("FAIL flush_byte: got %h want %h", got_data[0], b[0]);
            end
        end
        tb_read(R_STAT, r);
        total++;
        if (r[2] !== 1'b1 || r[1] !== 1'b0) begin
            bad++;
            $display("FAIL flush_status: empty=%b busy=%b want 1/0", r[2], r[1]);
        end
        ack_irq();
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] r;
        bit          ok;
        int          base_s;
        low_cycles = 20;
        base_s = start_rises;
        tb_write(R_ADDR, 16'h0055);
        tb_write(R_TXD, 16'h00A5);
        tb_write(R_TXD, 16'h005A);
        tb_write(R_CMD, 16'h0005);
        wait_rise(base_s, 50, ok);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({irq, i2c_start, i2c_addr, i2c_data, data_out} !== '0) begin
            bad++;
            $display("FAIL rst_mid: irq=%b start=%b addr=%h data=%h dout=%h want all 0",
                     irq, i2c_start, i2c_addr, i2c_data, data_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100 && !ready; i++) @(posedge clk);
        tb_read(R_STAT, r);
        total++;
        if (r !== 16'h0005) begin
            bad++;
            $display("FAIL rst_status: got %h want 0005", r);
        end
        got_data.delete();
        got_addr.delete();
        low_cycles = 5;
        tb_write(R_ADDR, 16'h0021);
        tb_write(R_TXD, 16'h00C3);
        tb_write(R_CMD, 16'h0005);
        wait_irq(300, ok);
        total++;
        if (!ok || got_data.size() != 1) begin
            bad++;
            $display("FAIL rst_reburst: irq=%b bytes=%0d want 1/1", ok, got_data.size());
        end else begin
            total++;
            if (got_data[0] !== 8'hC3 || got_addr[0] !== 7'h21) begin
                bad++;
                $display("FAIL rst_reburst_byte: got %h/%h want c3/21", got_data[0], got_addr[0]);
            end
        end
        ack_irq();
    endtask

    task automatic test_random_bursts();
        logic [7:0]  model_q[$];
        logic [15:0] r;
        logic [6:0]  a;
        logic [7:0]  v;
        bit          ok, exp_ovf;
        int          n, base_s;
        for (int it = 0; it < 6; it++) begin
            model_q.delete();
            got_data.delete();
            got_addr.delete();
            exp_ovf    = 1'b0;
            low_cycles = $urandom_range(2, 12);
            n          = $urandom_range(1, 10);
            a          = 7'($urandom_range(0, 127));
            base_s     = start_rises;
            tb_write(R_ADDR, {9'b0, a});
            for (int i = 0; i < n; i++) begin
                v = 8'($urandom_range(0, 255));
                tb_write(R_TXD, {8'h00, v});
                if (model_q.size() < DEPTH) model_q.push_back(v);
                else exp_ovf = 1'b1;
            end
            tb_read(R_STAT, r);
            total++;
            if (r[14:8] !== 7'(model_q.size()) || r[4] !== exp_ovf || r[3] !== (model_q.size() == DEPTH)) begin
                bad++;
                $display("FAIL rnd%0d_status: cnt=%0d ovf=%b full=%b want %0d/%b/%b", it, r[14:8], r[4], r[3],
                         model_q.size(), exp_ovf, model_q.size() == DEPTH);
            end
            tb_write(R_CMD, 16'h0005);
            wait_irq(1000, ok);
            total++;
            if (!ok || got_data.size() != model_q.size() || start_rises - base_s != model_q.size()) begin
                bad++;
                $display("FAIL rnd%0d_count: irq=%b bytes=%0d pulses=%0d want 1/%0d/%0d", it, ok,
                         got_data.size(), start_rises - base_s, model_q.size(), model_q.size());
            end
            for (int i = 0; i < model_q.size() && i < got_data.size(); i++) begin
                total++;
                if (got_data[i] !== model_q[i] || got_addr[i] !== a) begin
                    bad++;
                    $display("FAIL rnd%0d_byte%0d: got %h/%h want %h/%h", it, i, got_data[i], got_addr[i],
                             model_q[i], a);
                end
            end
            ack_irq();
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_overflow();
        test_timeout();
        test_empty_start();
        test_flush_mid_burst();
        test_reset_mid_burst();
        test_random_bursts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
